spi_flash_responder: RTL and testbench
======================================

// Module: spi_flash_responder
// PURPOSE
// - SPI mode-0 responder that emulates the subset of a serial NOR flash the bootloader SPI bridge drives.
// - Oversamples spi_cs/spi_sck/spi_mosi in the clk domain and decodes opcodes and addresses.
// - Serves data from an external byte memory over a 1-cycle-latency port.
// - Used as the far end of the flash interface: loopback boards and self-contained system benches.
// PARAMETERS
// - MEM_AW      16         byte-address width of backing memory; upper flash address bits ignored
// - JEDEC_ID    24'hEF4016 bytes returned by RDID, MSB first
// - SYNC_STAGES 2          synchronizer depth on spi_cs/spi_sck/spi_mosi (>=2)
// PORTS
// - clk          in   1       system clock; all logic on posedge
// - reset_n      in   1       asynchronous, active-low reset
// - spi_cs       in   1       chip select, active low
// - spi_sck      in   1       serial clock, mode 0; each phase >= SYNC_STAGES+3 clk cycles
// - spi_mosi     in   1       serial data in, MSB first
// - spi_miso     out  1       serial data out, MSB first
// - spi_miso_oe  out  1       MISO drive enable; equals synchronized (!spi_cs)
// - mem_addr     out  MEM_AW  backing memory byte address
// - mem_rd       out  1       1-cycle read strobe; mem_rdata valid the following cycle
// - mem_rdata    in   8       read data
// - mem_wr       out  1       1-cycle write strobe (program feature only)
// - mem_wdata    out  8       write data
// - busy         out  1       high while a transaction is in progress (synced cs low)
// BEHAVIOUR
// - Reset values: spi_miso=0, spi_miso_oe=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, WEL=0, state=IDLE.
// - Inputs pass through SYNC_STAGES flops; SCK edges come from registered previous vs. current value.
// - Rising SCK edge: shift mosi into rx_shift, bit_cnt++.
// - Falling SCK edge: shift tx_shift out on spi_miso.
// - Byte boundary: 8th rising edge. The next tx byte loads into tx_shift on the following falling edge, so its MSB is valid before the next rising edge.
// - Synced spi_cs high: aborts any state, returns to IDLE, discards partial bytes, drops busy/oe next cycle.
// - spi_cs falling starts a transaction in CMD with bit_cnt=0.
// - FSM: IDLE -> CMD -> {ADDR, ID, STAT, PROG*, IGNORE}; ADDR -> {READ, PROG*}.
// - 0x9F RDID -> ID: outputs JEDEC_ID[23:16], [15:8], [7:0], then 0x00 until cs high.
// - 0x05 RDSR -> STAT: status {6'b0, WEL, 1'b0}, repeated every byte. WIP is always 0.
// - 0x03 READ -> ADDR: 3 address bytes, MSB first; mem_addr = addr[MEM_AW-1:0].
//   - mem_rd pulses on the 24th rising edge; mem_rdata is captured into tx_next the next cycle.
//   - Each byte load into tx_shift increments mem_addr (modulo 2^MEM_AW, wrap to 0) and issues the next mem_rd.
// - Any other opcode -> IGNORE: spi_miso=0 until cs high.
// - During CMD/ADDR spi_miso=0.
// CONFIGURATION
// - Macro SPI_FLASH_RESPONDER_PROGRAM_EN.
// - Defined:
//   - 0x06 WREN sets WEL; 0x04 WRDI clears WEL. Each applies only if exactly 8 bits were clocked when cs rises.
//   - 0x02 PP with WEL=1: ADDR then PROG. Each complete data byte drives mem_wdata and mem_wr for 1 cycle, then mem_addr[7:0]++ (wraps within 256-byte page; upper bits fixed).
//   - WEL clears on cs rise ending PP.
//   - 0x02 with WEL=0 -> IGNORE.
// - Undefined: 0x06/0x04/0x02 -> IGNORE; WEL constant 0; mem_wr/mem_wdata tied 0.
// STRUCTURE
// - Package spi_flash_pkg holds:
//   - opcode localparams (OP_READ 8'h03, OP_RDSR 8'h05, OP_RDID 8'h9F, OP_WREN 8'h06, OP_WRDI 8'h04, OP_PP 8'h02)
//   - FSM state encoding
//   - status bit indices
// - Sub-module spi_sync_edge: synchronizer plus rise/fall detect; instanced once, 3-bit bus.
// TESTING
// - RDID: cs low, send 0x9F + 32 clocks -> MISO EF,40,16,00; spi_miso_oe=1 throughout, 0 two cycles after cs high.
// - READ: mem[i]=i^8'hA5; send 03 00 00 10 + 32 clocks -> MISO B5,B4,B7,B6; mem_rd at addr 0x0010..0x0013 (and prefetch 0x0014).
// - Wrap: READ at 0x00FFFF, MEM_AW=16 -> second byte from mem_addr 0x0000; addr byte 0xAB ignored for 0xABFFFF.
// - Abort: cs high after 13 bits of READ address -> IDLE, no mem_rd; following RDID returns EF,40,16.
// - Program (macro on): 06, then 02 00 01 FE 11 22 33 -> mem_wr at 0x01FE=11, 0x01FF=22, 0x0100=33.
//   - RDSR before PP reads 0x02, after reads 0x00.
//   - Macro off: same stream -> no mem_wr, RDSR reads 0x00.
// - Unknown 0x5A -> MISO 0 for 16 clocks. reset_n low mid-READ -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/spi_flash_responder_pkg.sv
// spi_flash_pkg: shared definitions for the SPI NOR flash responder.
//   - opcodes of the supported flash command subset
//   - FSM state encoding
//   - status register bit positions
package spi_flash_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_PP   = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_ID,
    ST_STAT,
    ST_PROG,
    ST_IGNORE
  } state_t;

  localparam int SR_WIP = 0;
  localparam int SR_WEL = 1;

endpackage

// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pins plus backing-memory port of the flash
// responder.
//   spi_cs/spi_sck/spi_mosi   serial bus from the SPI master
//   spi_miso/spi_miso_oe      serial data back to the master and its enable
//   mem_addr/mem_rd/mem_rdata byte memory read port (data one cycle after rd)
//   mem_wr/mem_wdata          byte memory write port
//   busy                      transaction in progress
// Modports: slave = responder side, master = bridge/memory side.
interface spi_flash_responder_if #(
  parameter int MEM_AW = 16
);
  logic              spi_cs;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic              busy;

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, mem_rdata,
    output spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, busy
  );

  modport master (
    output spi_cs, spi_sck, spi_mosi, mem_rdata,
    input  spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, busy
  );
endinterface

// File: rtl/spi_flash_responder_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for a small bus of asynchronous
// pins, with rising/falling edge pulses taken from the synchronized value
// against its one-cycle-delayed copy.
//   clk, reset_n   clock and asynchronous active-low reset
//   d_async[W]     raw pins
//   q[W]           synchronized pins
//   rise[W]/fall[W] single-cycle edge pulses
// RST_VAL sets the idle level of each pin so no false edge follows reset.
module spi_sync_edge #(
  parameter int           STAGES  = 2,
  parameter int           W       = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d_async,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] stage [STAGES];
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      stage[0] <= d_async;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[STAGES-1];
    end
  end

  assign q    = stage[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 responder emulating a serial NOR flash
// subset (READ, RDSR, RDID; optionally WREN/WRDI/PP) backed by an external
// byte memory with one cycle of read latency.
//   clk, reset_n  system clock, asynchronous active-low reset
//   bus (slave)   SPI pins, memory port and busy flag
// Parameters: MEM_AW memory address width, JEDEC_ID RDID bytes,
// SYNC_STAGES pin synchronizer depth.
// Build option: define SPI_FLASH_RESPONDER_PROGRAM_EN to enable WREN, WRDI
// and page program; otherwise those opcodes are ignored and the write port
// stays at 0.
//
// state     | meaning
// ST_IDLE   | cs high, waiting for cs fall
// ST_CMD    | shifting in the opcode
// ST_ADDR   | shifting in 3 address bytes
// ST_READ   | streaming memory bytes out
// ST_ID     | streaming JEDEC id, then zeros
// ST_STAT   | streaming the status byte
// ST_PROG   | writing received bytes into the page
// ST_IGNORE | unknown/finished opcode, MISO low until cs high
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int          MEM_AW      = 16,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  spi_flash_responder_if.slave bus
);
`ifdef SPI_FLASH_RESPONDER_PROGRAM_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic [2:0] pin_sync, pin_rise, pin_fall;

  // bit order {mosi, sck, cs}; cs idles high
  spi_sync_edge #(.STAGES(SYNC_STAGES), .W(3), .RST_VAL(3'b001)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_async ({bus.spi_mosi, bus.spi_sck, bus.spi_cs}),
    .q       (pin_sync),
    .rise    (pin_rise),
    .fall    (pin_fall)
  );

  logic cs_hi, cs_rise, cs_fall, sck_rise, sck_fall, mosi;
  assign cs_hi    = pin_sync[0];
  assign cs_rise  = pin_rise[0];
  assign cs_fall  = pin_fall[0];
  assign sck_rise = pin_rise[1];
  assign sck_fall = pin_fall[1];
  assign mosi     = pin_sync[2];

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shift, tx_shift, tx_next;
  logic              load_pend;
  logic [1:0]        byte_idx, id_idx;
  logic [15:0]       addr_hi;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              mem_rd_q, rd_dly, mem_wr_q;
  logic [7:0]        mem_wdata_q;
  logic              miso_q;
  logic              wel, wel_set, wel_clr, is_pp;

  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [23:0] full_addr;
  logic [7:0]  status;
  logic [7:0]  id_byte;

  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift[6:0], mosi};
  assign full_addr = {addr_hi, rx_byte};

  // flash address bits above MEM_AW are intentionally dropped
  logic unused_bits;
  assign unused_bits = ^{pin_rise[2], pin_fall[2], full_addr};

  always_comb begin
    status         = '0;
    status[SR_WEL] = wel;
  end

  always_comb begin
    case (id_idx)
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_next     <= '0;
      load_pend   <= 1'b0;
      byte_idx    <= '0;
      id_idx      <= '0;
      addr_hi     <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      rd_dly      <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      miso_q      <= 1'b0;
      wel         <= 1'b0;
      wel_set     <= 1'b0;
      wel_clr     <= 1'b0;
      is_pp       <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      rd_dly   <= mem_rd_q;
      // read data is valid the cycle after the strobe is seen by the memory
      if (rd_dly) tx_next <= bus.mem_rdata;
      // page program: advance within the 256-byte page after each write
      if (mem_wr_q) mem_addr_q[7:0] <= mem_addr_q[7:0] + 8'd1;

      if (cs_hi) begin
        state     <= ST_IDLE;
        bit_cnt   <= '0;
        tx_shift  <= '0;
        load_pend <= 1'b0;
        miso_q    <= 1'b0;
        is_pp     <= 1'b0;
        wel_set   <= 1'b0;
        wel_clr   <= 1'b0;
        if (cs_rise && PROG_EN) begin
          if (wel_set) wel <= 1'b1;
          else if (wel_clr || is_pp) wel <= 1'b0;
        end
      end else begin
        if (sck_rise) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
        end

        if (sck_fall) begin
          if (load_pend) begin
            miso_q    <= tx_next[7];
            tx_shift  <= {tx_next[6:0], 1'b0};
            load_pend <= 1'b0;
            if (state == ST_READ) begin
              mem_addr_q <= mem_addr_q + MEM_AW'(1);
              mem_rd_q   <= 1'b1;
            end
          end else begin
            miso_q   <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end

        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (byte_done) begin
              case (rx_byte)
                OP_READ: begin
                  state    <= ST_ADDR;
                  byte_idx <= '0;
                end
                OP_RDID: begin
                  state     <= ST_ID;
                  tx_next   <= JEDEC_ID[23:16];
                  id_idx    <= 2'd1;
                  load_pend <= 1'b1;
                end
                OP_RDSR: begin
                  state     <= ST_STAT;
                  tx_next   <= status;
                  load_pend <= 1'b1;
                end
                OP_WREN: begin
                  state   <= ST_IGNORE;
                  wel_set <= PROG_EN;
                end
                OP_WRDI: begin
                  state   <= ST_IGNORE;
                  wel_clr <= PROG_EN;
                end
                OP_PP: begin
                  if (PROG_EN && wel) begin
                    state    <= ST_ADDR;
                    byte_idx <= '0;
                    is_pp    <= 1'b1;
                  end else begin
                    state <= ST_IGNORE;
                  end
                end
                default: state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (byte_done) begin
              addr_hi  <= full_addr[15:0];
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd2) begin
                mem_addr_q <= full_addr[MEM_AW-1:0];
                if (is_pp) begin
                  state <= ST_PROG;
                end else begin
                  state     <= ST_READ;
                  mem_rd_q  <= 1'b1;
                  load_pend <= 1'b1;
                end
              end
            end
          end
          ST_READ: begin
            if (byte_done) load_pend <= 1'b1;
          end
          ST_ID: begin
            if (byte_done) begin
              tx_next   <= id_byte;
              load_pend <= 1'b1;
              if (id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end
          end
          ST_STAT: begin
            if (byte_done) begin
              tx_next   <= status;
              load_pend <= 1'b1;
            end
          end
          ST_PROG: begin
            if (byte_done && PROG_EN) begin
              mem_wdata_q <= rx_byte;
              mem_wr_q    <= 1'b1;
            end
          end
          ST_IGNORE: begin
            // any bit past the opcode cancels a pending WREN/WRDI
            if (sck_rise) begin
              wel_set <= 1'b0;
              wel_clr <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = ~cs_hi;
  assign bus.busy        = ~cs_hi;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
module tb_spi_flash_responder;
  localparam int          MEM_AW = 16;
  localparam logic [23:0] JEDEC  = 24'hEF4016;
`ifdef SPI_FLASH_RESPONDER_PROGRAM_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  spi_flash_responder_if #(.MEM_AW(MEM_AW)) bus();

  spi_flash_responder #(.MEM_AW(MEM_AW), .JEDEC_ID(JEDEC), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0]        mem [2**MEM_AW];
  logic [MEM_AW-1:0] rd_log[$];
  logic [23:0]       wr_log[$];
  int checks = 0;
  int failures = 0;
  int half = 6;

  always @(posedge clk) if (bus.mem_rd === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.mem_rd === 1'b1) rd_log.push_back(bus.mem_addr);
    if (reset_n === 1'b1 && bus.mem_wr === 1'b1) wr_log.push_back({bus.mem_addr, bus.mem_wdata});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got hang, want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [28:0] out_vec();
    return {bus.spi_miso, bus.spi_miso_oe, bus.mem_rd, bus.mem_wr,
            bus.mem_addr, bus.mem_wdata, bus.busy};
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output bit oe_ok);
    rx = '0;
    oe_ok = 1'b1;
    for (int i = 7; i >= 8 - n; i--) begin
      bus.spi_mosi = tx[i];
      wait_clks(half);
      rx[i] = bus.spi_miso;
      if (bus.spi_miso_oe !== 1'b1 || bus.busy !== 1'b1) oe_ok = 1'b0;
      bus.spi_sck = 1'b1;
      wait_clks(half);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic xact(input bq_t txq, output bq_t rxq, output bit oe_ok);
    logic [7:0] r;
    bit ok;
    rxq = {};
    oe_ok = 1'b1;
    half = $urandom_range(6, 8);
    bus.spi_cs = 1'b0;
    wait_clks(half);
    foreach (txq[i]) begin
      spi_bits(txq[i], 8, r, ok);
      rxq.push_back(r);
      if (!ok) oe_ok = 1'b0;
    end
  endtask

  task automatic cs_end();
    wait_clks(half);
    bus.spi_cs = 1'b1;
    wait_clks(8);
  endtask

  task automatic do_cmd(input logic [7:0] op);
    bq_t tx, rx;
    bit ok;
    tx.push_back(op);
    xact(tx, rx, ok);
    cs_end();
  endtask

  task automatic do_rdsr(output logic [7:0] sr);
    bq_t tx, rx;
    bit ok;
    tx.push_back(8'h05);
    tx.push_back(8'h00);
    tx.push_back(8'h00);
    xact(tx, rx, ok);
    cs_end();
    // status repeats every byte; a disagreement surfaces as a wrong value
    sr = (rx[1] === rx[2]) ? rx[1] : 8'hXX;
  endtask

  task automatic test_reset();
    logic [7:0] sr;
    reset_n = 1'b0;
    bus.spi_cs = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    wait_clks(3);
    checks++;
    if (out_vec() !== '0) begin
      failures++;
      $display("FAIL reset_hold: outputs=%h want 0", out_vec());
    end
    reset_n = 1'b1;
    wait_clks(5);
    checks++;
    if (out_vec() !== '0) begin
      failures++;
      $display("FAIL reset_release: outputs=%h want 0", out_vec());
    end
    do_rdsr(sr);
    checks++;
    if (sr !== 8'h00) begin
      failures++;
      $display("FAIL reset_rdsr: got %h want 00", sr);
    end
  endtask

  task automatic test_rdid();
    bq_t tx, rx;
    bit ok;
    logic [7:0] exp;
    tx.push_back(8'h9F);
    repeat (4) tx.push_back(8'($urandom));
    xact(tx, rx, ok);
    for (int k = 0; k < 4; k++) begin
      exp = (k < 3) ? JEDEC[23 - 8*k -: 8] : 8'h00;
      checks++;
      if (rx[k+1] !== exp) begin
        failures++;
        $display("FAIL rdid_byte%0d: got %h want %h", k, rx[k+1], exp);
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rdid_oe: oe/busy dropped during transfer, want 1");
    end
    wait_clks(half);
    bus.spi_cs = 1'b1;
    wait_clks(2);
    checks++;
    if (bus.spi_miso_oe !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rdid_oe_drop: oe=%b busy=%b want 0", bus.spi_miso_oe, bus.busy);
    end
    wait_clks(6);
  endtask

  // READ of n bytes from a 24-bit flash address, checked against the memory
  task automatic run_read(input string name, input logic [23:0] addr, input int n);
    bq_t tx, rx;
    bit ok;
    logic [MEM_AW-1:0] a;
    rd_log.delete();
    tx.push_back(8'h03);
    tx.push_back(addr[23:16]);
    tx.push_back(addr[15:8]);
    tx.push_back(addr[7:0]);
    repeat (n) tx.push_back(8'($urandom));
    xact(tx, rx, ok);
    cs_end();
    for (int k = 0; k < n; k++) begin
      a = MEM_AW'((addr + 24'(k)) % (1 << MEM_AW));
      checks++;
      if (rx[4+k] !== mem[a]) begin
        failures++;
        $display("FAIL %s_data%0d: got %h want %h (mem %h)", name, k, rx[4+k], mem[a], a);
      end
    end
    checks++;
    if (rd_log.size() < n + 1) begin
      failures++;
      $display("FAIL %s_rd_count: got %0d want >=%0d", name, rd_log.size(), n + 1);
    end else begin
      for (int k = 0; k <= n; k++) begin
        a = MEM_AW'((addr + 24'(k)) % (1 << MEM_AW));
        checks++;
        if (rd_log[k] !== a) begin
          failures++;
          $display("FAIL %s_rd_addr%0d: got %h want %h", name, k, rd_log[k], a);
        end
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] exp [4];
    bq_t tx, rx;
    bit ok;
    for (int i = 0; i < 2**MEM_AW; i++) mem[i] = 8'(i) ^ 8'hA5;
    exp[0] = 8'hB5; exp[1] = 8'hB4; exp[2] = 8'hB7; exp[3] = 8'hB6;
    tx.push_back(8'h03); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h10);
    repeat (4) tx.push_back(8'h00);
    rd_log.delete();
    xact(tx, rx, ok);
    cs_end();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx[4+k] !== exp[k]) begin
        failures++;
        $display("FAIL read_fixed%0d: got %h want %h", k, rx[4+k], exp[k]);
      end
    end
    run_read("read_pat", 24'h000010, 4);
  endtask

  task automatic test_read_random();
    for (int i = 0; i < 2**MEM_AW; i++) mem[i] = 8'($urandom);
    for (int it = 0; it < 3; it++)
      run_read("read_rand", 24'($urandom), $urandom_range(1, 4));
  endtask

  task automatic test_wrap();
    run_read("wrap", 24'hABFFFF, 2);
  endtask

  task automatic test_abort();
    bq_t tx, rx;
    bit ok;
    logic [7:0] r;
    rd_log.delete();
    tx.push_back(8'h03);
    tx.push_back(8'h12);
    xact(tx, rx, ok);
    spi_bits(8'h34, 5, r, ok);
    cs_end();
    checks++;
    if (rd_log.size() != 0) begin
      failures++;
      $display("FAIL abort_no_rd: got %0d reads want 0", rd_log.size());
    end
    tx = {};
    tx.push_back(8'h9F);
    repeat (3) tx.push_back(8'h00);
    xact(tx, rx, ok);
    cs_end();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx[k+1] !== JEDEC[23 - 8*k -: 8]) begin
        failures++;
        $display("FAIL abort_rdid%0d: got %h want %h", k, rx[k+1], JEDEC[23 - 8*k -: 8]);
      end
    end
  endtask

  task automatic test_unknown();
    bq_t tx, rx;
    bit ok;
    tx.push_back(8'h5A);
    tx.push_back(8'($urandom));
    tx.push_back(8'($urandom));
    xact(tx, rx, ok);
    cs_end();
    checks++;
    if ({rx[1], rx[2]} !== 16'h0000 || !ok) begin
      failures++;
      $display("FAIL unknown_op: got %h%h oe_ok=%0d want 0000 oe_ok=1", rx[1], rx[2], ok);
    end
  endtask

  task automatic test_program();
    bit wel_m = 1'b0;
    logic [7:0] sr;
    bq_t tx, rx, dat;
    bit ok;
    logic [7:0] r;
    logic [23:0] exp_w[$];
    logic [15:0] base;
    int n;

    do_rdsr(sr);
    checks++;
    if (sr !== {6'b0, wel_m, 1'b0}) begin
      failures++;
      $display("FAIL prog_rdsr_initial: got %h want %h", sr, {6'b0, wel_m, 1'b0});
    end
    do_cmd(8'h06);
    wel_m = PROG;
    do_rdsr(sr);
    checks++;
    if (sr !== {6'b0, wel_m, 1'b0}) begin
      failures++;
      $display("FAIL prog_rdsr_wren: got %h want %h", sr, {6'b0, wel_m, 1'b0});
    end

    // fixed page-program stream crossing the page end
    for (int pass = 0; pass < 2; pass++) begin
      tx = {};
      dat = {};
      exp_w = {};
      if (pass == 0) begin
        base = 16'h01FE;
        dat.push_back(8'h11); dat.push_back(8'h22); dat.push_back(8'h33);
      end else begin
        do_cmd(8'h06);
        wel_m = PROG;
        base = {8'($urandom), 8'($urandom_range(248, 255))};
        n = $urandom_range(2, 5);
        repeat (n) dat.push_back(8'($urandom));
      end
      tx.push_back(8'h02); tx.push_back(8'h00); tx.push_back(base[15:8]); tx.push_back(base[7:0]);
      foreach (dat[k]) begin
        tx.push_back(dat[k]);
        if (wel_m) exp_w.push_back({base[15:8], 8'(base[7:0] + 8'(k)), dat[k]});
      end
      wr_log.delete();
      xact(tx, rx, ok);
      cs_end();
      wel_m = 1'b0;
      checks++;
      if (wr_log.size() != exp_w.size()) begin
        failures++;
        $display("FAIL prog_wr_count%0d: got %0d want %0d", pass, wr_log.size(), exp_w.size());
      end else begin
        foreach (exp_w[k]) begin
          checks++;
          if (wr_log[k] !== exp_w[k]) begin
            failures++;
            $display("FAIL prog_wr%0d_%0d: got addr/data %h want %h", pass, k, wr_log[k], exp_w[k]);
          end
        end
      end
      do_rdsr(sr);
      checks++;
      if (sr !== {6'b0, wel_m, 1'b0}) begin
        failures++;
        $display("FAIL prog_rdsr_after%0d: got %h want %h", pass, sr, {6'b0, wel_m, 1'b0});
      end
    end

    // WREN followed by a ninth bit must not set WEL
    tx = {};
    tx.push_back(8'h06);
    xact(tx, rx, ok);
    spi_bits(8'h80, 1, r, ok);
    cs_end();
    do_rdsr(sr);
    checks++;
    if (sr !== 8'h00) begin
      failures++;
      $display("FAIL prog_wren_9bits: got %h want 00", sr);
    end

    // WREN then WRDI clears; PP then has no effect
    do_cmd(8'h06);
    do_cmd(8'h04);
    do_rdsr(sr);
    checks++;
    if (sr !== 8'h00) begin
      failures++;
      $display("FAIL prog_wrdi: got %h want 00", sr);
    end
    tx = {};
    tx.push_back(8'h02); tx.push_back(8'h00); tx.push_back(8'h02); tx.push_back(8'h00);
    tx.push_back(8'hAA);
    wr_log.delete();
    xact(tx, rx, ok);
    cs_end();
    checks++;
    if (wr_log.size() != 0) begin
      failures++;
      $display("FAIL prog_no_wel: got %0d writes want 0", wr_log.size());
    end
  endtask

  task automatic test_async_reset();
    bq_t tx, rx;
    bit ok;
    logic [7:0] r;
    tx.push_back(8'h03); tx.push_back(8'h00); tx.push_back(8'h01); tx.push_back(8'h37);
    tx.push_back(8'h00);
    xact(tx, rx, ok);
    spi_bits(8'h00, 5, r, ok);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== '0) begin
      failures++;
      $display("FAIL async_reset: outputs=%h want 0", out_vec());
    end
    bus.spi_cs = 1'b1;
    bus.spi_sck = 1'b0;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(5);
    tx = {};
    tx.push_back(8'h9F);
    tx.push_back(8'h00);
    xact(tx, rx, ok);
    cs_end();
    checks++;
    if (rx[1] !== JEDEC[23:16]) begin
      failures++;
      $display("FAIL async_reset_recover: got %h want %h", rx[1], JEDEC[23:16]);
    end
  endtask

  initial begin
    test_reset();
    test_rdid();
    test_read();
    test_read_random();
    test_wrap();
    test_abort();
    test_unknown();
    test_program();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
